b2_bcd: RTL and testbench

B2_BCD -- requirements
Module: b2_bcd

---
 rtl/b2_bcd_pkg.sv | 20 ++
 rtl/bcd_dd_core.sv | 47 ++++
 rtl/b2_bcd.sv | 83 ++++++++
 tb/tb_b2_bcd.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/b2_bcd_pkg.sv
// rtl/b2_bcd_pkg.sv - shared constants, sequencer states and digit correction for b2_bcd
`timescale 1ns/1ps
package b2_bcd_pkg;

  localparam int IN_W         = 12;
  localparam int DIGITS       = 4;
  localparam int SHIFT_CYCLES = 12;

  typedef enum logic [1:0] {
    LOAD,
    SHIFT,
    UPDATE
  } seq_state_t;

  // Double-dabble pre-shift correction: a digit >= 5 would overflow past 9 once doubled.
  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/bcd_dd_core.sv
// rtl/bcd_dd_core.sv - one channel of double-dabble: binary shift register, BCD accumulator, output digits
`timescale 1ns/1ps
module bcd_dd_core #(
  parameter int IN_W   = 12,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_en,
  input  logic                  shift_en,
  input  logic                  update_en,
  input  logic [IN_W-1:0]       din,
  output logic [4*DIGITS-1:0]   dout
);
  import b2_bcd_pkg::*;

  logic [IN_W-1:0]     bin_q;
  logic [4*DIGITS-1:0] acc_q;
  logic [4*DIGITS-1:0] acc_adj;

  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < DIGITS; i++) begin
      acc_adj[4*i +: 4] = add3(acc_q[4*i +: 4]);
    end
  end

  // Outputs only move on update_en, so partial sums never become visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q <= '0;
      acc_q <= '0;
      dout  <= '0;
    end else begin
      if (load_en) begin
        bin_q <= din;
        acc_q <= '0;
      end else if (shift_en) begin
        {acc_q, bin_q} <= {acc_adj, bin_q} << 1;
      end
      if (update_en) begin
        dout <= acc_q;
      end
    end
  end

endmodule

// File: rtl/b2_bcd.sv
// rtl/b2_bcd.sv - free-running dual-channel binary to BCD converter with a shared sequencer
`timescale 1ns/1ps
module b2_bcd #(
  parameter int IN_W   = 12,
  parameter int DIGITS = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IN_W-1:0] v1,
  input  logic [IN_W-1:0] v2,
  output logic [3:0]      DV10,
  output logic [3:0]      DV11,
  output logic [3:0]      DV12,
  output logic [3:0]      DV13,
  output logic [3:0]      DV20,
  output logic [3:0]      DV21,
  output logic [3:0]      DV22,
  output logic [3:0]      DV23
);
  import b2_bcd_pkg::*;

  seq_state_t          state, state_nxt;
  logic [3:0]          cnt;
  logic                load_en, shift_en, update_en;
  logic [4*DIGITS-1:0] d1, d2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state == SHIFT) ? cnt + 4'd1 : 4'd0;
    end
  end

  // LOAD(1) + SHIFT(12) + UPDATE(1) gives a fixed 14-cycle period.
  always_comb begin
    state_nxt = state;
    load_en   = 1'b0;
    shift_en  = 1'b0;
    update_en = 1'b0;
    case (state)
      LOAD: begin
        load_en   = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (cnt == 4'(SHIFT_CYCLES - 1)) state_nxt = UPDATE;
      end
      UPDATE: begin
        update_en = 1'b1;
        state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  bcd_dd_core #(.IN_W(IN_W), .DIGITS(DIGITS)) u_ch1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_en   (load_en),
    .shift_en  (shift_en),
    .update_en (update_en),
    .din       (v1),
    .dout      (d1)
  );

  bcd_dd_core #(.IN_W(IN_W), .DIGITS(DIGITS)) u_ch2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_en   (load_en),
    .shift_en  (shift_en),
    .update_en (update_en),
    .din       (v2),
    .dout      (d2)
  );

  assign {DV13, DV12, DV11, DV10} = d1[15:0];
  assign {DV23, DV22, DV21, DV20} = d2[15:0];

endmodule

// File: tb/tb_b2_bcd.sv
// tb/tb_b2_bcd.sv - self-checking bench for b2_bcd against a decimal-arithmetic reference
`timescale 1ns/1ps
module tb_b2_bcd;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] v1, v2;
  logic [3:0]  DV10, DV11, DV12, DV13, DV20, DV21, DV22, DV23;

  int checks = 0;
  int fails  = 0;
  int edge_cnt = 0;

  wire [15:0] ch1 = {DV13, DV12, DV11, DV10};
  wire [15:0] ch2 = {DV23, DV22, DV21, DV20};

  b2_bcd dut (
    .clk   (clk),
    .rst_n (rst_n),
    .v1    (v1),
    .v2    (v2),
    .DV10  (DV10),
    .DV11  (DV11),
    .DV12  (DV12),
    .DV13  (DV13),
    .DV20  (DV20),
    .DV21  (DV21),
    .DV22  (DV22),
    .DV23  (DV23)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, edge_cnt=%0d", edge_cnt);
    $fatal(1, "watchdog");
  end

  // Decimal digits by plain division, thousands digit in the top nibble.
  function automatic logic [15:0] model_bcd(input int v);
    logic [15:0] m;
    int r;
    r = v;
    for (int k = 0; k < 4; k++) begin
      m[4*k +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return m;
  endfunction

  // Advances one clock and returns at the following falling edge.
  task automatic tick();
    @(posedge clk);
    edge_cnt++;
    @(negedge clk);
  endtask

  // Moves to a point where the next rising edge is a LOAD edge.
  task automatic align();
    for (int i = 0; i < 14; i++) begin
      if (edge_cnt % 14 != 0) tick();
    end
  endtask

  task automatic convert(input int a, input int b);
    align();
    v1 = 12'(a);
    v2 = 12'(b);
    repeat (14) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    v1 = 12'd0;
    v2 = 12'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ch1, ch2} !== 32'h0) begin
      fails++;
      $display("FAIL reset_outputs: got %h required %h", {ch1, ch2}, 32'h0);
    end
    rst_n = 1'b1;
    edge_cnt = 0;
  endtask

  task automatic test_basic();
    convert(412, 3123);
    checks++;
    if (ch1 !== model_bcd(412)) begin
      fails++;
      $display("FAIL basic_ch1: got %h required %h", ch1, model_bcd(412));
    end
    checks++;
    if (ch2 !== model_bcd(3123)) begin
      fails++;
      $display("FAIL basic_ch2: got %h required %h", ch2, model_bcd(3123));
    end
  endtask

  task automatic test_extremes();
    convert(0, 4095);
    checks++;
    if (ch1 !== model_bcd(0)) begin
      fails++;
      $display("FAIL extreme_ch1: got %h required %h", ch1, model_bcd(0));
    end
    checks++;
    if (ch2 !== model_bcd(4095)) begin
      fails++;
      $display("FAIL extreme_ch2: got %h required %h", ch2, model_bcd(4095));
    end
  endtask

  task automatic test_hold();
    convert(999, 1000);
    checks++;
    if (ch1 !== model_bcd(999) || ch2 !== model_bcd(1000)) begin
      fails++;
      $display("FAIL hold_value: got %h/%h required %h/%h", ch1, ch2, model_bcd(999), model_bcd(1000));
    end
    v1 = 12'd5;
    v2 = 12'd6;
    for (int i = 0; i < 13; i++) begin
      tick();
      checks++;
      if (ch1 !== model_bcd(999) || ch2 !== model_bcd(1000)) begin
        fails++;
        $display("FAIL hold_stable cycle %0d: got %h/%h required %h/%h", i, ch1, ch2, model_bcd(999), model_bcd(1000));
      end
    end
  endtask

  task automatic test_input_change();
    align();
    v1 = 12'd412;
    v2 = 12'd55;
    repeat (6) tick();
    v1 = 12'd7;
    repeat (8) tick();
    checks++;
    if (ch1 !== model_bcd(412) || ch2 !== model_bcd(55)) begin
      fails++;
      $display("FAIL change_first: got %h/%h required %h/%h", ch1, ch2, model_bcd(412), model_bcd(55));
    end
    repeat (14) tick();
    checks++;
    if (ch1 !== model_bcd(7)) begin
      fails++;
      $display("FAIL change_next: got %h required %h", ch1, model_bcd(7));
    end
  endtask

  task automatic test_reset_mid();
    convert(321, 4000);
    checks++;
    if (ch1 !== model_bcd(321) || ch2 !== model_bcd(4000)) begin
      fails++;
      $display("FAIL pre_reset: got %h/%h required %h/%h", ch1, ch2, model_bcd(321), model_bcd(4000));
    end
    align();
    v1 = 12'd1234;
    v2 = 12'd567;
    repeat (6) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ch1, ch2} !== 32'h0) begin
      fails++;
      $display("FAIL midreset_clear: got %h required %h", {ch1, ch2}, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    edge_cnt = 0;
    repeat (13) tick();
    checks++;
    if ({ch1, ch2} !== 32'h0) begin
      fails++;
      $display("FAIL midreset_early: got %h required %h", {ch1, ch2}, 32'h0);
    end
    tick();
    checks++;
    if (ch1 !== model_bcd(1234) || ch2 !== model_bcd(567)) begin
      fails++;
      $display("FAIL midreset_result: got %h/%h required %h/%h", ch1, ch2, model_bcd(1234), model_bcd(567));
    end
  endtask

  task automatic test_random_sweep();
    for (int n = 0; n < 200; n++) begin
      int a, b, s1, s2;
      bit range_ok;
      a = int'($urandom_range(0, 4095));
      b = int'($urandom_range(0, 4095));
      convert(a, b);
      checks++;
      if (ch1 !== model_bcd(a)) begin
        fails++;
        $display("FAIL sweep_ch1 v1=%0d: got %h required %h", a, ch1, model_bcd(a));
      end
      checks++;
      if (ch2 !== model_bcd(b)) begin
        fails++;
        $display("FAIL sweep_ch2 v2=%0d: got %h required %h", b, ch2, model_bcd(b));
      end
      range_ok = (DV10 <= 9) && (DV11 <= 9) && (DV12 <= 9) && (DV13 <= 4) &&
                 (DV20 <= 9) && (DV21 <= 9) && (DV22 <= 9) && (DV23 <= 4);
      checks++;
      if (range_ok !== 1'b1) begin
        fails++;
        $display("FAIL sweep_range: got %h/%h required all digits in range", ch1, ch2);
      end
      s1 = int'(DV13) * 1000 + int'(DV12) * 100 + int'(DV11) * 10 + int'(DV10);
      s2 = int'(DV23) * 1000 + int'(DV22) * 100 + int'(DV21) * 10 + int'(DV20);
      checks++;
      if (s1 !== a || s2 !== b) begin
        fails++;
        $display("FAIL sweep_sum: got %0d/%0d required %0d/%0d", s1, s2, a, b);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_hold();
    test_input_change();
    test_reset_mid();
    test_random_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
